// File: rtl/wb_pkg.sv
// Shared Wishbone/SRAM definitions: slave FSM states,
// default SRAM timing and memory-map constants.
package wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE,
    S_ERROR
  } wb_state_e;

  localparam int          DEF_READ_WAIT  = 2;
  localparam int          DEF_WRITE_WAIT = 2;
  localparam logic [31:0] SRAM_BASE      = 32'h8000_0000;

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic slave driving a 32-bit async SRAM bank.
// Every output is registered from the next-state decode.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int          ADDR_W     = 20,
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE,
  parameter int          READ_WAIT  = DEF_READ_WAIT,
  parameter int          WRITE_WAIT = DEF_WRITE_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int MAXW = (READ_WAIT > WRITE_WAIT) ?
                        READ_WAIT : WRITE_WAIT;
  localparam int CW   = $clog2(MAXW + 1);

  wb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic [3:0]    sel_q, sel_d;
  logic          req, hit, take;
  logic          rd_d, wr_d;

  assign wb_rty_o = 1'b0;
  assign req  = wb_cyc_i & wb_stb_i;
  assign hit  = ((wb_adr_i - BASE_ADDR) >> (ADDR_W + 2)) == 32'd0;
  assign take = (state_q == S_IDLE) & req & hit & (wb_sel_i != 4'h0);
  assign sel_d = (state_q == S_IDLE) ? wb_sel_i : sel_q;
  assign rd_d = (state_d == S_READ);
  assign wr_d = (state_d == S_WR_SETUP) | (state_d == S_WR_PULSE) |
                (state_d == S_WR_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          abort_d = 1'b0;
          if (!hit) begin
            state_d = S_ERROR;
          end else if (wb_sel_i == 4'h0) begin
            state_d = S_DONE;
          end else if (wb_we_i) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_READ;
            cnt_d   = CW'(READ_WAIT - 1);
          end
        end
      end
      S_READ: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SETUP: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        state_d = S_WR_PULSE;
        cnt_d   = CW'(WRITE_WAIT - 1);
      end
      S_WR_PULSE: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // an abort seen anywhere in the write still completes the hold
      S_WR_HOLD: begin
        state_d = (abort_q || !wb_cyc_i) ? S_IDLE : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      sel_q        <= 4'h0;
      wb_dat_o     <= 32'h0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      sram_addr    <= '0;
      sram_data_o  <= 32'h0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      if (take) begin
        sel_q       <= wb_sel_i;
        sram_addr   <= wb_adr_i[ADDR_W+1:2];
        sram_data_o <= wb_dat_i;
      end
      if (state_q == S_READ && state_d == S_DONE)
        wb_dat_o <= sram_data_i;
      wb_ack_o     <= (state_d == S_DONE);
      wb_err_o     <= (state_d == S_ERROR);
      sram_ce_n    <= !(rd_d | wr_d);
      sram_oe_n    <= !rd_d;
      sram_we_n    <= (state_d != S_WR_PULSE);
      sram_data_oe <= wr_d;
      if (rd_d)      sram_be_n <= 4'h0;
      else if (wr_d) sram_be_n <= ~sel_d;
      else           sram_be_n <= 4'hF;
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave against a
// behavioural 16-word SRAM model.
module tb_wb_sram_slave;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]   wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data_o, sram_data_i;
  logic          sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  wb_sram_slave #(
    .ADDR_W(AW), .BASE_ADDR(32'h8000_0000),
    .READ_WAIT(2), .WRITE_WAIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i), .sram_data_oe(sram_data_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i * 32'h0101));
  endfunction

  // SRAM model: reinitialised while rst is high
  logic [31:0] mem [0:15];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ?
                       mem[sram_addr[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          mem[sram_addr[3:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  // free-running activity monitor; tests use deltas
  int cyc = 0, ce_low = 0, oe_low = 0, we_low = 0;
  int clash = 0, acks = 0, errs = 0;
  logic [7:0] wpat = '0;
  logic [3:0] be_seen = 4'hF;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_low  <= ce_low + 1;
      wpat    <= {wpat[6:0], sram_we_n};
      be_seen <= sram_be_n;
    end
    if (!sram_oe_n) oe_low <= oe_low + 1;
    if (!sram_we_n) we_low <= we_low + 1;
    if (!sram_oe_n && sram_data_oe) clash <= clash + 1;
    if (wb_ack_o) acks <= acks + 1;
    if (wb_err_o) errs <= errs + 1;
  end

  int b_ce, b_oe, b_we, b_ack, b_err, b_clash;
  task automatic snap();
    b_ce = ce_low; b_oe = oe_low; b_we = we_low;
    b_ack = acks; b_err = errs; b_clash = clash;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // single access from a negedge; lat counts edges to ack/err, -1 on timeout
  task automatic access(input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic [3:0] sel,
                        output int lat, output logic ack,
                        output logic err);
    wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = adr;
    wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
    lat = -1; ack = 0; err = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) begin
        lat = i; ack = wb_ack_o; err = wb_err_o;
        break;
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    wb_adr_i = 32'hFFFF_FFFF; wb_dat_i = 32'h0BAD_0BAD; wb_sel_i = 4'h0;
  endtask

  task automatic wait_we_low(output logic ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle(3);
    n_cmp++;
    if ({wb_ack_o, wb_err_o, wb_rty_o, sram_data_oe} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_bus ack/err/rty/oe got %b want 0000",
               {wb_ack_o, wb_err_o, wb_rty_o, sram_data_oe});
    end
    n_cmp++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin
      n_bad++;
      $display("FAIL reset_strobes got %h want 7f",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
    end
    n_cmp++;
    if (wb_dat_o !== 0 || sram_addr !== 0 || sram_data_o !== 0) begin
      n_bad++;
      $display("FAIL reset_data dat_o=%h addr=%h data_o=%h want 0",
               wb_dat_o, sram_addr, sram_data_o);
    end
    rst = 0;
    idle(1);
  endtask

  task automatic test_read();
    int lat; logic ack, err;
    snap();
    sb.push_back(init_word(4));
    access(32'h8000_0010, 32'h0, 1'b0, 4'hF, lat, ack, err);
    n_cmp++;
    if (lat != 3 || !ack) begin
      n_bad++;
      $display("FAIL read_latency got %0d ack=%b want 3 ack=1", lat, ack);
    end
    n_cmp++;
    if (ack && sb.size() > 0) begin
      logic [31:0] e = sb.pop_front();
      if (wb_dat_o !== e) begin
        n_bad++;
        $display("FAIL read_data got %h want %h", wb_dat_o, e);
      end
    end else begin
      n_bad++;
      $display("FAIL read_data no ack to pop scoreboard");
    end
    n_cmp++;
    if (sram_addr !== AW'(4)) begin
      n_bad++;
      $display("FAIL read_addr got %0d want 4", sram_addr);
    end
    idle(2);
    n_cmp++;
    if (ce_low - b_ce != 2 || oe_low - b_oe != 2 || acks - b_ack != 1) begin
      n_bad++;
      $display("FAIL read_strobes ce=%0d oe=%0d acks=%0d want 2 2 1",
               ce_low - b_ce, oe_low - b_oe, acks - b_ack);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, last = 0, done = 0;
    sb.delete();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
    wb_adr_i = 32'h8000_0000;
    sb.push_back(init_word(0));
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        n_cmp++;
        if (sb.size() == 0 || wb_dat_o !== sb[0]) begin
          n_bad++;
          $display("FAIL b2b_data[%0d] got %h want %h", n, wb_dat_o,
                   sb.size() ? sb[0] : 32'hx);
        end
        if (sb.size()) void'(sb.pop_front());
        if (n > 0) begin
          n_cmp++;
          if (cyc - last != 4) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d] got %0d want 4", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n < 3) begin
          wb_adr_i = 32'h8000_0000 + 32'(4 * n);
          sb.push_back(init_word(n));
        end else begin
          wb_cyc_i = 0; wb_stb_i = 0; done = 1;
        end
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    n_cmp++;
    if (n != 3) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 3", n);
    end
    idle(2);
  endtask

  task automatic test_write();
    int lat; logic ack, err;
    logic [31:0] e;
    e = init_word(2);
    e[23:16] = 8'h22;
    snap();
    access(32'h8000_0008, 32'h1122_3344, 1'b1, 4'b0100, lat, ack, err);
    n_cmp++;
    if (lat != 5 || !ack) begin
      n_bad++;
      $display("FAIL write_latency got %0d ack=%b want 5 ack=1", lat, ack);
    end
    idle(2);
    n_cmp++;
    if (we_low - b_we != 2 || ce_low - b_ce != 4 || wpat[3:0] !== 4'b1001) begin
      n_bad++;
      $display("FAIL write_pulse we=%0d ce=%0d pat=%b want 2 4 1001",
               we_low - b_we, ce_low - b_ce, wpat[3:0]);
    end
    n_cmp++;
    if (be_seen !== 4'b1011 || oe_low != b_oe || clash != b_clash) begin
      n_bad++;
      $display("FAIL write_be_oe be=%b oe=%0d clash=%0d want 1011 0 0",
               be_seen, oe_low - b_oe, clash - b_clash);
    end
    n_cmp++;
    if (mem[2] !== e || acks - b_ack != 1) begin
      n_bad++;
      $display("FAIL write_mem got %h acks=%0d want %h 1",
               mem[2], acks - b_ack, e);
    end
  endtask

  task automatic test_decode_miss();
    logic [31:0] adrs [2];
    int lat; logic ack, err;
    adrs[0] = 32'h7FFF_FFFC;
    adrs[1] = 32'h8040_0000;
    foreach (adrs[k]) begin
      snap();
      access(adrs[k], 32'h0, 1'b0, 4'hF, lat, ack, err);
      idle(2);
      n_cmp++;
      if (lat != 1 || !err || ack || errs - b_err != 1 ||
          acks != b_ack || ce_low != b_ce) begin
        n_bad++;
        $display("FAIL miss_%h lat=%0d err=%b ack=%b errs=%0d ce=%0d",
                 adrs[k], lat, err, ack, errs - b_err, ce_low - b_ce);
      end
    end
  endtask

  task automatic test_abort();
    logic ok;
    snap();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h8000_0014; wb_dat_i = 32'h55AA_55AA;
    wait_we_low(ok);
    wb_cyc_i = 0; wb_stb_i = 0; wb_dat_i = 32'h0;
    idle(8);
    n_cmp++;
    if (!ok || we_low - b_we != 2 || acks != b_ack || mem[5] !== 32'h55AA_55AA) begin
      n_bad++;
      $display("FAIL abort_write ok=%b we=%0d acks=%0d mem=%h want 2 0 55aa55aa",
               ok, we_low - b_we, acks - b_ack, mem[5]);
    end
    n_cmp++;
    if (sram_ce_n !== 1'b1 || sram_data_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_write_idle ce_n=%b oe=%b want 1 0",
               sram_ce_n, sram_data_oe);
    end
    snap();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h8000_000C;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_oe_n) begin ok = 1; break; end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    n_cmp++;
    if (!ok || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_read ok=%b ce_n=%b oe_n=%b want 1 1 1",
               ok, sram_ce_n, sram_oe_n);
    end
    idle(6);
    n_cmp++;
    if (acks != b_ack || errs != b_err) begin
      n_bad++;
      $display("FAIL abort_read_ack acks=%0d errs=%0d want 0 0",
               acks - b_ack, errs - b_err);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic ack, err, ok;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h8000_0018; wb_dat_i = 32'h1234_5678;
    wait_we_low(ok);
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if (!ok || {sram_we_n, sram_ce_n, sram_be_n, sram_data_oe, wb_ack_o}
               !== 8'b1111_1100) begin
      n_bad++;
      $display("FAIL reset_mid_write ok=%b we/ce/be/oe/ack=%b want 11111100",
               ok, {sram_we_n, sram_ce_n, sram_be_n, sram_data_oe, wb_ack_o});
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    rst = 0;
    idle(1);
    sb.push_back(init_word(7));
    access(32'h8000_001C, 32'h0, 1'b0, 4'hF, lat, ack, err);
    n_cmp++;
    if (lat != 3 || !ack || sb.size() == 0) begin
      n_bad++;
      $display("FAIL post_reset_read lat=%0d ack=%b want 3 1", lat, ack);
    end else begin
      logic [31:0] e = sb.pop_front();
      if (wb_dat_o !== e) begin
        n_bad++;
        $display("FAIL post_reset_read data got %h want %h", wb_dat_o, e);
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_decode_miss();
    test_abort();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
Wishbone B4 classic slave (responder) that serves the data/instruction-side Wishbone master requests for the external 32-bit asynchronous SRAM.
- Decodes an address window and converts each single-beat cycle into a timed SRAM read or write sequence with byte enables.
- Returns data with a single-cycle ack.
- Sits on the bus side of the interconnect, one instance per SRAM bank.

Parameters:
ADDR_W, 20, SRAM word-address width (bank = 2^ADDR_W words)
BASE_ADDR, 32'h8000_0000, byte base of decoded window
READ_WAIT, 2, cycles ce_n/oe_n held low before read data is sampled (>=1)
WRITE_WAIT, 2, cycles we_n held low per write (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_we_i  in  1  1=write
wb_sel_i  in  4  byte select
wb_dat_o  out  32  read data, registered
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination (decode miss)
wb_rty_o  out  1  retry; constant 0
sram_addr  out  ADDR_W  word address
sram_data_o  out  32  write data to pad
sram_data_i  in  32  read data from pad
sram_data_oe  out  1  1=drive pad (tristate resolved at top level)
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte enables, active low

Behaviour:
- All outputs registered. No combinational path from wb_*_i to any output.
- Reset (sync, clk edge with rst=1), takes priority over everything:
  - state=IDLE, count=0
  - ack=err=0, wb_dat_o=0
  - ce_n=oe_n=we_n=1, be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_data_o=0
  - reset mid-operation aborts immediately with no ack.
- Request = wb_cyc_i & wb_stb_i, sampled only in IDLE. On acceptance, latch adr[ADDR_W+1:2], dat_i, sel, we.
- Hit = (wb_adr_i - BASE_ADDR) < 4*2^ADDR_W. adr[1:0] is ignored; sel defines the bytes.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE, ERROR.
- Request accepted in cycle T:
  - Miss: ERROR at T+1, err=1 for one cycle, no SRAM activity, then IDLE.
  - sel==0: DONE at T+1, ack=1, no SRAM activity. Reads return wb_dat_o unchanged.
  - Read: READ for T+1..T+READ_WAIT with ce_n=0, oe_n=0, be_n=0000 (whole word).
    - sram_data_i is sampled into wb_dat_o on the last READ cycle.
    - DONE at T+READ_WAIT+1: ack=1, wb_dat_o valid. Latency READ_WAIT+1.
  - Write:
    - WR_SETUP at T+1: ce_n=0, be_n=~sel, sram_data_oe=1, we_n=1.
    - WR_PULSE for T+2..T+1+WRITE_WAIT: we_n=0.
    - WR_HOLD at T+2+WRITE_WAIT: we_n=1, data/addr/be still driven.
    - DONE at T+3+WRITE_WAIT: ack=1, sram_data_oe=0, ce_n=1. Latency WRITE_WAIT+3.
- oe_n=1 whenever sram_data_oe=1. These two are never both active in the same cycle.
- DONE/ERROR last exactly one cycle, then IDLE. IDLE may accept a new request the cycle after DONE, so back-to-back reads issue every READ_WAIT+2 cycles.
- ack and err are never both 1. ack/err are never asserted unless cyc was high in the accepting cycle.
- Master abort (wb_cyc_i=0 while busy):
  - In READ: go to IDLE next cycle, SRAM strobes released, no ack.
  - In WR_SETUP/WR_PULSE/WR_HOLD: finish the pulse and hold (protects SRAM timing), then go to IDLE, no ack.
- wb_adr_i/dat_i/sel_i changes after acceptance are ignored (latched copy used).
- Counter width = clog2(max(READ_WAIT,WRITE_WAIT)+1). It reloads on each state entry.

Decomposition:
- Shared package (e.g. wb_pkg): Wishbone slave state enum, default SRAM timing constants (READ_WAIT/WRITE_WAIT defaults), BASE_ADDR constants for the memory map.
- Single module with no sub-module. The wait counter is a few lines inline.
- Tristate pad is instantiated at the top level, not here.

Test Plan:
- Reset, then read 0x8000_0010 with SRAM word 4 = 0xDEADBEEF, READ_WAIT=2 -> sram_addr=4, ce_n/oe_n low for 2 cycles, ack at T+3 with wb_dat_o=0xDEADBEEF, exactly one ack.
- Write 0x8000_0008, dat=0x11223344, sel=4'b0100, WRITE_WAIT=2 -> be_n=4'b1011, we_n low exactly 2 cycles bracketed by setup/hold, ack at T+5, oe_n never low; SRAM word 2 byte2=0x22 only.
- Access 0x7FFF_FFFC and 0x8040_0000 (ADDR_W=20) -> err=1 one cycle at T+1, ack=0, ce_n stays 1.
- Back-to-back reads of words 0,1,2 with stb held high -> three acks spaced READ_WAIT+2 cycles, data in order.
- Drop cyc during WR_PULSE -> we_n pulse completes full WRITE_WAIT, then IDLE, no ack. Drop cyc during READ -> IDLE next cycle, no ack.
- Assert rst mid-WR_PULSE -> next edge: we_n=ce_n=1, be_n=4'hF, sram_data_oe=0, ack=0, state IDLE; a following read completes normally.
